// File: rtl/wb_master_pipelined_if.sv
// rtl/wb_master_pipelined_if.sv - Wishbone B4 pipelined bus signals with master/slave views
interface wb_master_pipelined_if #(
    parameter int adr_width = 16,
    parameter int dat_width = 16
);
    logic                 cyc_o;
    logic                 stb_o;
    logic                 we_o;
    logic [adr_width-1:0] adr_o;
    logic [dat_width-1:0] dat_o;
    logic [dat_width-1:0] dat_i;
    logic                 ack_i;
    logic                 err_i;
    logic                 stall_i;

    modport master (
        output cyc_o, stb_o, we_o, adr_o, dat_o,
        input  dat_i, ack_i, err_i, stall_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, adr_o, dat_o,
        output dat_i, ack_i, err_i, stall_i
    );
endinterface

// File: rtl/wb_master_pipelined.sv
// rtl/wb_master_pipelined.sv - Wishbone B4 pipelined block master; WB_MASTER_TIMEOUT_EN adds an ack watchdog
module wb_master_pipelined #(
    parameter int adr_width = 16,
    parameter int dat_width = 16,
    parameter int len_width = 8,
    parameter int timeout   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_we,
    input  logic [adr_width-1:0] cmd_adr,
    input  logic [len_width-1:0] cmd_len,
    input  logic                 wdat_valid,
    output logic                 wdat_ready,
    input  logic [dat_width-1:0] wdat,
    output logic                 rd_valid,
    output logic [dat_width-1:0] rd_dat,
    output logic                 done,
    output logic                 err,
    wb_master_pipelined_if.master wb
);
    localparam int cnt_width = len_width + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t               state_q, state_d;
    logic                 we_q, we_d;
    logic [adr_width-1:0] adr_q, adr_d;
    logic [cnt_width-1:0] remain_q, remain_d;
    logic [cnt_width-1:0] outst_q, outst_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [dat_width-1:0] rd_dat_q, rd_dat_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic                 want_stb;
    logic                 issue_raw;
    logic                 issue;
    logic                 ack_ok;
    logic                 abort;
    logic                 wdog_hit;

    // A write beat is offered only while the stream has a word; reads offer every ISSUE cycle.
    assign want_stb  = (state_q == ISSUE) && (!we_q || wdat_valid);
    assign issue_raw = want_stb && !wb.stall_i;
    assign abort     = (state_q != IDLE) && (wb.err_i || wdog_hit);

    // Strobe is withdrawn in the aborting cycle so no beat slips out behind an error.
    assign wb.stb_o  = want_stb && !abort;
    assign wb.cyc_o  = (state_q != IDLE);
    assign wb.we_o   = we_q;
    assign wb.adr_o  = adr_q;
    assign wb.dat_o  = ((state_q == ISSUE) && we_q) ? wdat : '0;

    assign issue      = wb.stb_o && !wb.stall_i;
    assign ack_ok     = wb.ack_i && (outst_q != '0);
    assign wdat_ready = issue && we_q;
    assign cmd_ready  = rst && (state_q == IDLE);
    assign rd_valid   = rd_valid_q;
    assign rd_dat     = rd_dat_q;
    assign done       = done_q;
    assign err        = err_q;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int wdog_width = $clog2(timeout + 1);

    logic [wdog_width-1:0] wdog_q, wdog_d;
    logic                  wdog_run;

    // The beat-issue cycle counts, so the abort lands exactly timeout cycles after the first beat.
    assign wdog_run = (state_q != IDLE) && ((outst_q != '0) || issue_raw) && !wb.ack_i;
    assign wdog_hit = wdog_run && (wdog_q == wdog_width'(timeout - 1));
    assign wdog_d   = wdog_run ? wdog_q + wdog_width'(1) : '0;

    // Watchdog counter: clears on every ack and whenever nothing is pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    logic timeout_unused;

    assign wdog_hit       = 1'b0;
    assign timeout_unused = (timeout != 0);
`endif

    // Next-state logic: command latch, beat issue, ack accounting, completion and abort.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        adr_d      = adr_q;
        remain_d   = remain_q;
        outst_d    = outst_q;
        rd_valid_d = 1'b0;
        rd_dat_d   = rd_dat_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    we_d     = cmd_we;
                    adr_d    = cmd_adr;
                    remain_d = {1'b0, cmd_len} + cnt_width'(1);
                    outst_d  = '0;
                    state_d  = ISSUE;
                end
            end
            default: begin
                if (abort) begin
                    remain_d = '0;
                    outst_d  = '0;
                    done_d   = 1'b1;
                    err_d    = 1'b1;
                    state_d  = IDLE;
                end else begin
                    if (issue) begin
                        adr_d    = adr_q + adr_width'(1);
                        remain_d = remain_q - cnt_width'(1);
                        if (remain_q == cnt_width'(1)) begin
                            state_d = WAIT;
                        end
                    end
                    unique case ({issue, ack_ok})
                        2'b10:   outst_d = outst_q + cnt_width'(1);
                        2'b01:   outst_d = outst_q - cnt_width'(1);
                        default: outst_d = outst_q;
                    endcase
                    if (ack_ok && !we_q) begin
                        rd_valid_d = 1'b1;
                        rd_dat_d   = wb.dat_i;
                    end
                    if ((state_q == WAIT) && ack_ok && (outst_q == cnt_width'(1))) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    // FSM and registered outputs; reset drops the bus immediately and discards the block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            adr_q      <= '0;
            remain_q   <= '0;
            outst_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_dat_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            remain_q   <= remain_d;
            outst_q    <= outst_d;
            rd_valid_q <= rd_valid_d;
            rd_dat_q   <= rd_dat_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_wb_master_pipelined.sv
// tb/tb_wb_master_pipelined.sv - scoreboard bench for wb_master_pipelined with a pipelined slave model
module tb_wb_master_pipelined;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_adr;
    logic [LW-1:0] cmd_len;
    logic          wdat_valid, wdat_ready;
    logic [DW-1:0] wdat;
    logic          rd_valid;
    logic [DW-1:0] rd_dat;
    logic          done, err;

    wb_master_pipelined_if #(.adr_width(AW), .dat_width(DW)) wb ();

    wb_master_pipelined #(.adr_width(AW), .dat_width(DW), .len_width(LW), .timeout(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_len(cmd_len),
        .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat(wdat),
        .rd_valid(rd_valid), .rd_dat(rd_dat), .done(done), .err(err),
        .wb(wb)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0, cyc_n = 0, blk_cyc = 0;
    int stall_lo = 1000, stall_hi = 0, starve_lo = 1000, starve_hi = 0;
    int err_at = 0, resp_cnt = 0;
    int beat_cnt = 0, ack_cnt = 0, rdv_cnt = 0;
    int first_beat_cyc = 0, last_beat_cyc = 0, last_ack_cyc = 0, last_rdv_cyc = 0;
    int done_cyc = 0, err_cyc = 0, acc_cyc = 0;
    bit noack = 0, stray_req = 0, resp_pend = 0, consumed = 0, done_flag = 0, hold_prev = 0;
    logic [DW-1:0]    resp_dat;
    logic [AW+DW:0]   hold_vec;
    logic [DW-1:0]    mem [int];
    logic [DW-1:0]    wq[$];
    logic [DW-1:0]    exp_wdat[$];
    logic [DW-1:0]    exp_rd[$];
    logic [AW-1:0]    exp_adr[$];
    bit               exp_done[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] outs_vec();
        return {8'h0, wb.cyc_o, wb.stb_o, wb.we_o, wb.adr_o, wb.dat_o,
                cmd_ready, wdat_ready, rd_valid, rd_dat, done, err};
    endfunction

    // Slave + stream environment: drive inputs just after each falling edge, then sample and score.
    initial begin
        wb.ack_i = 1'b0; wb.err_i = 1'b0; wb.stall_i = 1'b0; wb.dat_i = '0;
        wdat_valid = 1'b0; wdat = '0;
        forever begin
            @(negedge clk);
            cyc_n++;
            if (!rst) begin
                wb.ack_i = 1'b0; wb.err_i = 1'b0; wb.stall_i = 1'b0; wb.dat_i = '0;
                wdat_valid = 1'b0; wdat = '0;
                resp_pend = 0; consumed = 0; blk_cyc = 0; hold_prev = 0;
                continue;
            end
            if (consumed && wq.size() > 0) void'(wq.pop_front());
            blk_cyc    = wb.cyc_o ? blk_cyc + 1 : 0;
            wdat_valid = (wq.size() > 0) && !(blk_cyc >= starve_lo && blk_cyc <= starve_hi);
            wdat       = (wq.size() > 0) ? wq[0] : '0;
            wb.stall_i = (blk_cyc >= stall_lo && blk_cyc <= stall_hi);
            wb.ack_i = 1'b0; wb.err_i = 1'b0; wb.dat_i = '0;
            if (resp_pend) begin
                resp_cnt++;
                if (resp_cnt == err_at) begin
                    wb.err_i = 1'b1; err_cyc = cyc_n;
                end else begin
                    wb.ack_i = 1'b1; wb.dat_i = resp_dat; ack_cnt++; last_ack_cyc = cyc_n;
                end
                resp_pend = 0;
            end else if (stray_req) begin
                wb.ack_i = 1'b1; wb.dat_i = 16'hDEAD; stray_req = 0;
            end
            #1;
            if (hold_prev) chk("stall_hold", {wb.we_o, wb.adr_o, wb.dat_o}, hold_vec);
            hold_prev = wb.stb_o && wb.stall_i;
            hold_vec  = {wb.we_o, wb.adr_o, wb.dat_o};
            if (wb.cyc_o && wb.stb_o && !wb.stall_i) begin
                if (beat_cnt == 0) first_beat_cyc = cyc_n;
                beat_cnt++; last_beat_cyc = cyc_n;
                chk("beat_expected", exp_adr.size() != 0, 1);
                if (exp_adr.size() != 0) chk("beat_adr", wb.adr_o, exp_adr.pop_front());
                if (wb.we_o) begin
                    if (exp_wdat.size() != 0) chk("beat_wdat", wb.dat_o, exp_wdat.pop_front());
                    mem[int'(wb.adr_o)] = wb.dat_o;
                end
                if (!noack && !wb.err_i) begin
                    resp_pend = 1;
                    resp_dat  = (!wb.we_o && mem.exists(int'(wb.adr_o))) ? mem[int'(wb.adr_o)] : '0;
                end
            end
            if (rd_valid) begin
                rdv_cnt++; last_rdv_cyc = cyc_n;
                chk("rd_expected", exp_rd.size() != 0, 1);
                if (exp_rd.size() != 0) chk("rd_dat", rd_dat, exp_rd.pop_front());
            end
            if (done) begin
                done_cyc = cyc_n; done_flag = 1;
                chk("done_expected", exp_done.size() != 0, 1);
                if (exp_done.size() != 0) chk("done_err", err, exp_done.pop_front());
                chk("done_cyc_low", wb.cyc_o, 0);
            end else if (err) begin
                chk("err_qualified", done, 1);
            end
            consumed = wdat_valid && wdat_ready;
        end
    end

    task automatic issue_cmd(input bit we, input logic [AW-1:0] adr, input logic [LW-1:0] len);
        beat_cnt = 0; ack_cnt = 0; rdv_cnt = 0; resp_cnt = 0; done_flag = 0;
        for (int i = 0; i < 50 && !cmd_ready; i++) begin @(negedge clk); #2; end
        chk("cmd_ready_seen", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_len = len;
        acc_cyc = cyc_n;
        @(posedge clk); #2;
        cmd_valid = 1'b0;
    endtask

    task automatic run_block(input bit we, input logic [AW-1:0] adr, input logic [LW-1:0] len);
        issue_cmd(we, adr, len);
        for (int i = 0; i < 300 && !done_flag; i++) @(negedge clk);
        #2;
        chk("block_done_seen", done_flag, 1);
        repeat (2) @(negedge clk);
        #2;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    // Directed sequence.
    initial begin
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_len = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("reset_outputs", outs_vec(), 64'h0);
        rst = 1'b1;
        @(negedge clk); #2;
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_cyc", wb.cyc_o, 0);

        // Write 10 beats at 11..20, stream always valid, no stall.
        for (int i = 0; i < 10; i++) begin
            wq.push_back(DW'(211 + i)); exp_wdat.push_back(DW'(211 + i)); exp_adr.push_back(AW'(11 + i));
        end
        exp_done.push_back(1'b0);
        run_block(1'b1, 16'd11, 8'd9);
        chk("t1_first_beat", first_beat_cyc, acc_cyc + 1);
        chk("t1_back_to_back", last_beat_cyc - first_beat_cyc, 9);
        chk("t1_beats", beat_cnt, 10);
        chk("t1_done_after_ack", done_cyc, last_ack_cyc + 1);

        // Read back 11..20.
        for (int i = 0; i < 10; i++) begin
            exp_adr.push_back(AW'(11 + i)); exp_rd.push_back(DW'(211 + i));
        end
        exp_done.push_back(1'b0);
        run_block(1'b0, 16'd11, 8'd9);
        chk("t2_rd_count", rdv_cnt, 10);
        chk("t2_done_with_last_rd", done_cyc, last_rdv_cyc);

        // Single beat at the top of the address space, then a two-beat wrap.
        mem[32'hFFFF] = 16'hA5A5; mem[0] = 16'h1234;
        exp_adr.push_back(16'hFFFF); exp_rd.push_back(16'hA5A5); exp_done.push_back(1'b0);
        run_block(1'b0, 16'hFFFF, 8'd0);
        chk("t3_single_beat", beat_cnt, 1);
        chk("t3_done_after_ack", done_cyc, last_ack_cyc + 1);
        exp_adr.push_back(16'hFFFF); exp_adr.push_back(16'h0000);
        exp_rd.push_back(16'hA5A5); exp_rd.push_back(16'h1234); exp_done.push_back(1'b0);
        run_block(1'b0, 16'hFFFF, 8'd1);
        chk("t3_wrap_rd_count", rdv_cnt, 2);

        // Write with a 3-cycle stall and a 2-cycle stream gap.
        stall_lo = 3; stall_hi = 5; starve_lo = 7; starve_hi = 8;
        for (int i = 0; i < 10; i++) begin
            wq.push_back(DW'(300 + i)); exp_wdat.push_back(DW'(300 + i)); exp_adr.push_back(AW'(100 + i));
        end
        exp_done.push_back(1'b0);
        run_block(1'b1, 16'd100, 8'd9);
        stall_lo = 1000; stall_hi = 0; starve_lo = 1000; starve_hi = 0;
        chk("t4_beats", beat_cnt, 10);
        chk("t4_acks", ack_cnt, 10);
        chk("t4_stream_drained", wq.size(), 0);

        // Error on the third response of an 8-beat read, then a stray ack.
        for (int i = 0; i < 8; i++) mem[40 + i] = DW'(500 + i);
        exp_adr.push_back(16'd40); exp_adr.push_back(16'd41); exp_adr.push_back(16'd42);
        exp_rd.push_back(16'd500); exp_rd.push_back(16'd501); exp_done.push_back(1'b1);
        err_at = 3;
        run_block(1'b0, 16'd40, 8'd7);
        err_at = 0;
        chk("t5_done_after_err", done_cyc, err_cyc + 1);
        chk("t5_beats", beat_cnt, 3);
        stray_req = 1;
        repeat (4) @(negedge clk);
        #2;
        chk("t5_stray_ignored", rdv_cnt, 2);
        chk("t5_idle_after_stray", cmd_ready, 1);

`ifdef WB_MASTER_TIMEOUT_EN
        // Slave never acks: watchdog aborts 16 cycles after the first beat.
        noack = 1;
        for (int i = 0; i < 4; i++) exp_adr.push_back(AW'(11 + i));
        exp_done.push_back(1'b1);
        run_block(1'b0, 16'd11, 8'd3);
        noack = 0;
        chk("to_done_time", done_cyc, first_beat_cyc + 16);
`endif

        // Reset in the middle of a write block, then a normal read.
        for (int i = 0; i < 10; i++) begin
            wq.push_back(DW'(700 + i)); exp_wdat.push_back(DW'(700 + i)); exp_adr.push_back(AW'(200 + i));
        end
        issue_cmd(1'b1, 16'd200, 8'd9);
        repeat (3) @(negedge clk);
        #2;
        chk("t6_mid_block_cyc", wb.cyc_o, 1);
        rst = 1'b0;
        #1;
        chk("t6_reset_outputs", outs_vec(), 64'h0);
        wq.delete(); exp_wdat.delete(); exp_adr.delete(); exp_rd.delete(); exp_done.delete();
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("t6_ready_after_reset", cmd_ready, 1);
        @(negedge clk); #2;
        for (int i = 0; i < 3; i++) begin
            exp_adr.push_back(AW'(11 + i)); exp_rd.push_back(DW'(211 + i));
        end
        exp_done.push_back(1'b0);
        run_block(1'b0, 16'd11, 8'd2);
        chk("t6_rd_count", rdv_cnt, 3);
        chk("t6_scoreboard_empty", exp_adr.size() + exp_rd.size() + exp_done.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/wb_master_pipelined.md
# wb_master_pipelined

Wishbone B4 pipelined-mode bus master engine. Accepts a block command (start address, beat count, direction), issues one pipelined Wishbone cycle of consecutive-address single-word accesses, and tracks outstanding acknowledges. Write data comes from a ready/valid stream; read data leaves on a registered valid strobe. It is the initiator counterpart of `wb_slave_pipelined` and the synthesizable replacement for the bench-side pipelined master tasks.

## Interface
- `adr_width`, 16: Wishbone address width.
- `dat_width`, 16: Wishbone data width.
- `len_width`, 8: beat-count field width; max block is 2**len_width beats.
- `timeout`, 255: ack watchdog limit in cycles; used only with `WB_MASTER_TIMEOUT_EN`.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_we`  in  1  1 = write block, 0 = read block.
- `cmd_adr`  in  adr_width  start address.
- `cmd_len`  in  len_width  beats minus 1.
- `wdat_valid`  in  1  write data available.
- `wdat_ready`  out  1  write word consumed this cycle.
- `wdat`  in  dat_width  write data.
- `rd_valid`  out  1  read word valid, one-cycle pulse, no backpressure.
- `rd_dat`  out  dat_width  read data.
- `done`  out  1  one-cycle pulse at block end.
- `err`  out  1  qualifies `done`: block ended by `err_i` or timeout.
- `cyc_o`, `stb_o`, `we_o`  out  1  Wishbone control.
- `adr_o`  out  adr_width  Wishbone address.
- `dat_o`  out  dat_width  Wishbone write data.
- `dat_i`  in  dat_width  Wishbone read data.
- `ack_i`, `err_i`, `stall_i`  in  1  Wishbone slave responses.

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: `cmd_ready`=1. `cmd_valid`&&`cmd_ready` latches we, adr, beats = len+1, then goes to ISSUE.
- ISSUE: `cyc_o`=1. For reads, `stb_o`=1 every cycle. For writes, `stb_o`=`wdat_valid`; `dat_o`=`wdat`; `wdat_ready` = `stb_o`&&!`stall_i`.
- Beat issued when `stb_o`&&!`stall_i`. Then `adr_o` increments by 1 (wraps modulo 2**adr_width), remaining count decrements, outstanding increments.
- After the last beat is issued, go to WAIT with `stb_o`=0.
- Ack: each `ack_i` with outstanding > 0 decrements outstanding. On a read, register `dat_i` to `rd_dat` and pulse `rd_valid` the next cycle. `ack_i` with outstanding = 0 is ignored.
- A simultaneous issue and ack in one cycle leaves outstanding unchanged.
- Outstanding counter width is len_width+1.
- WAIT: when the final ack arrives (all beats issued, outstanding reaches 0), go to IDLE. `cyc_o` is low from the next cycle, and `done` pulses in that cycle.
- `err_i` in ISSUE or WAIT aborts the block:
  - stop issuing; no further beats;
  - next cycle: `cyc_o`=`stb_o`=0, `done`=`err`=1;
  - go to IDLE;
  - any late acks are ignored.
- `err` is 0 except on an aborting `done`.
- Reset (`rst`=0, any time): all outputs 0, state IDLE, counters 0. This drops `cyc_o` mid-cycle. The partial block is lost, with no `done`.

## Timing
- Command accepted at edge N → `cyc_o`/`stb_o`/`adr_o` valid after edge N, i.e. the first beat can be issued in cycle N+1.
- With no stall and no write starvation, L beats issue in L consecutive cycles.
- `rd_valid` follows its `ack_i` by 1 cycle. `done` follows the final ack by 1 cycle, coinciding with the last `rd_valid`.
- `cmd_ready` is high again in the `done` cycle. A new command is accepted there at the earliest, so the minimum gap between blocks is one idle cycle of `cyc_o`=0.
- `adr_o`, `we_o`, `dat_o` hold stable while `stall_i`=1.

## Configuration
- `WB_MASTER_TIMEOUT_EN` defined:
  - a watchdog counts cycles in ISSUE/WAIT with outstanding > 0 and no `ack_i`, and clears on each ack;
  - reaching `timeout` aborts the block exactly as `err_i` does (`done`=`err`=1).
- Undefined: no watchdog; the engine waits for acks indefinitely, and `timeout` is unused.

## Test plan
- Write block, adr 11, len 9, `wdat` 211..220 always valid, slave no stall → 10 beats on consecutive cycles at adr 11..20; `done` 1 cycle after 10th ack; `err`=0. Readback shows 211..220.
- Read block, adr 11, len 9 → `rd_valid` 10 pulses, `rd_dat` 211..220 in order; `done` coincides with the last pulse.
- Read block, len 0, adr 0xFFFF → single beat at 0xFFFF; `cyc_o` low one cycle after ack. Repeat with len 1: addresses 0xFFFF then 0x0000.
- Write with `stall_i` high for 3 cycles mid-block and `wdat_valid` low for 2 cycles → `adr_o`/`dat_o` held; no beat lost or duplicated; outstanding never exceeds issued beats.
- `err_i` on 3rd ack of an 8-beat read → no further beats; next cycle `cyc_o`=0, `done`=`err`=1. A stray `ack_i` afterwards is ignored.
- With `WB_MASTER_TIMEOUT_EN` and `timeout`=16, slave never acks → `done`=`err`=1 16 cycles after the first beat. `rst` pulsed mid-block → all outputs 0 immediately; next command executes normally.
